// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types and helpers for clock/reset controllers
// Contents: pll_state_e (one-hot sequencer states), RELOCK_W, cnt_width().

package pll_ctrl_pkg;

    localparam int RELOCK_W = 8;

    typedef enum logic [3:0] {
        RESET_PLL = 4'b0001,
        WAIT_LOCK = 4'b0010,
        STABILIZE = 4'b0100,
        RUN       = 4'b1000
    } pll_state_e;

    // Width of a down-counter that must hold the largest of three cycle
    // counts; the extra bit keeps loads of (N-1) clear of the top bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL control and system-reset status bundle
// Signals: pll_locked (from PLL, async), pll_rst (to PLL), sys_rst, ready,
//          relock_count[RELOCK_W], timeout_err.
// master: the sequencer side; slave: the PLL/consumer side.

interface pll_reset_sequencer_if;
    import pll_ctrl_pkg::*;

    logic                pll_locked;
    logic                pll_rst;
    logic                sys_rst;
    logic                ready;
    logic [RELOCK_W-1:0] relock_count;
    logic                timeout_err;

    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst,
        output ready,
        output relock_count,
        output timeout_err
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  relock_count,
        input  timeout_err
    );

endinterface

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - N-flop single-bit synchronizer, synchronous reset to 0
// Ports: clk, rst (sync, active-high), d (async input), q (synchronized).

module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification, system reset release
// Ports: refclk (50 MHz), rst (sync, active-high), bus (pll_reset_sequencer_if.master):
//        pll_locked in, pll_rst/sys_rst/ready/relock_count/timeout_err out.

module pll_reset_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000
) (
    input  logic                   refclk,
    input  logic                   rst,
    pll_reset_sequencer_if.master  bus
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic                locked_s;

    pll_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_rst_q, sys_rst_d;
    logic                ready_q, ready_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                timeout_err_q, timeout_err_d;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_locked_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        relock_d      = relock_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TO_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock is checked first so it wins over an expiring timeout.
                if (locked_s) begin
                    state_d = STABILIZE;
                    cnt_d   = STABLE_LOAD;
                end else if (cnt_q == '0) begin
                    state_d       = RESET_PLL;
                    cnt_d         = RST_LOAD;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TO_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = RESET_PLL;
                    cnt_d   = RST_LOAD;
                    if (relock_q != '1) begin
                        relock_d = relock_q + RELOCK_W'(1);
                    end
                end
            end
            default: begin
                // Non-one-hot state: restart the PLL sequence.
                state_d = RESET_PLL;
                cnt_d   = RST_LOAD;
            end
        endcase

        // Outputs decode the next state so they are flops aligned with state_q.
        pll_rst_d = (state_d == RESET_PLL);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= RESET_PLL;
            cnt_q         <= RST_LOAD;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            relock_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_q     <= sys_rst_d;
            ready_q       <= ready_d;
            relock_q      <= relock_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_rst      = sys_rst_q;
    assign bus.ready        = ready_q;
    assign bus.relock_count = relock_q;
    assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic [7:0] relock;
        logic       terr;
    } exp_t;

    typedef struct {
        logic rst;
        logic locked;
        int   n;
        exp_t e;
    } vec_t;

    logic  refclk = 1'b0;
    logic  rst;
    int    checks = 0;
    int    errors = 0;
    exp_t  sb[$];
    vec_t  vecs[$];

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES         (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #10 refclk = ~refclk;

    function automatic void add(input logic r, input logic l, input int n,
                                input logic p, input logic s, input logic rd,
                                input logic [7:0] rc, input logic te);
        vec_t v;
        v.rst = r;
        v.locked = l;
        v.n = n;
        v.e = '{pll_rst: p, sys_rst: s, ready: rd, relock: rc, terr: te};
        vecs.push_back(v);
    endfunction

    // Drive one cycle; when chk is set the expected outputs are queued and
    // compared against the DUT after the edge.
    task automatic cycle(input logic r, input logic l, input bit chk,
                         input exp_t e, input int tag);
        exp_t got;
        exp_t want;
        rst = r;
        bus.pll_locked = l;
        if (chk) sb.push_back(e);
        @(posedge refclk);
        #1;
        if (chk) begin
            got  = {bus.pll_rst, bus.sys_rst, bus.ready, bus.relock_count, bus.timeout_err};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL step%0d t=%0t: got pll_rst=%b sys_rst=%b ready=%b relock=%0d terr=%b, want pll_rst=%b sys_rst=%b ready=%b relock=%0d terr=%b",
                         tag, $time, got.pll_rst, got.sys_rst, got.ready, got.relock, got.terr,
                         want.pll_rst, want.sys_rst, want.ready, want.relock, want.terr);
            end
        end
    endtask

    initial begin
        exp_t e;
        int   k;
        logic [7:0] rc_exp;

        rst = 1'b1;
        bus.pll_locked = 1'b0;

        //   rst l   n  pll sys rdy rc te
        // reset release, pll_rst high for exactly 4 edges
        add(1, 0,  2, 1, 1, 0, 0, 0);
        add(0, 0,  3, 1, 1, 0, 0, 0);
        add(0, 0,  1, 0, 1, 0, 0, 0);
        // clean lock 5 cycles into WAIT_LOCK, ready 11 edges after rise
        add(0, 0,  4, 0, 1, 0, 0, 0);
        add(0, 1, 10, 0, 1, 0, 0, 0);
        add(0, 1,  1, 0, 0, 1, 0, 0);
        add(0, 1,  3, 0, 0, 1, 0, 0);
        // loss of lock in RUN: reset asserted 3 edges later
        add(0, 0,  2, 0, 0, 1, 0, 0);
        add(0, 0,  1, 1, 1, 0, 1, 0);
        add(0, 0,  3, 1, 1, 0, 1, 0);
        add(0, 0,  1, 0, 1, 0, 1, 0);
        // timeout after 32 WAIT_LOCK cycles, twice; timeout_err sticky
        add(0, 0, 31, 0, 1, 0, 1, 0);
        add(0, 0,  1, 1, 1, 0, 1, 1);
        add(0, 0,  3, 1, 1, 0, 1, 1);
        add(0, 0,  1, 0, 1, 0, 1, 1);
        add(0, 0, 31, 0, 1, 0, 1, 1);
        add(0, 0,  1, 1, 1, 0, 1, 1);
        add(0, 0,  3, 1, 1, 0, 1, 1);
        add(0, 0,  1, 0, 1, 0, 1, 1);
        // chatter 4 cycles into STABILIZE, ready 11 edges after final rise
        add(0, 1,  7, 0, 1, 0, 1, 1);
        add(0, 0,  1, 0, 1, 0, 1, 1);
        add(0, 1, 10, 0, 1, 0, 1, 1);
        add(0, 1,  1, 0, 0, 1, 1, 1);
        // second relock, then reset while in STABILIZE
        add(0, 0,  2, 0, 0, 1, 1, 1);
        add(0, 0,  1, 1, 1, 0, 2, 1);
        add(0, 0,  3, 1, 1, 0, 2, 1);
        add(0, 0,  1, 0, 1, 0, 2, 1);
        add(0, 1,  3, 0, 1, 0, 2, 1);
        add(1, 1,  1, 1, 1, 0, 0, 0);
        add(0, 1,  3, 1, 1, 0, 0, 0);
        add(0, 1,  1, 0, 1, 0, 0, 0);
        add(0, 1,  8, 0, 1, 0, 0, 0);
        add(0, 1,  1, 0, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                cycle(vecs[i].rst, vecs[i].locked, 1'b1, vecs[i].e, i);
            end
        end

        // 300 RUN lock losses: relock_count must saturate at 255
        for (int i = 1; i <= 300; i++) begin
            rc_exp = (i > 255) ? 8'd255 : 8'(i);
            e = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, relock: rc_exp, terr: 1'b0};
            cycle(1'b0, 1'b0, 1'b0, e, 1000 + i);
            cycle(1'b0, 1'b0, 1'b0, e, 1000 + i);
            cycle(1'b0, 1'b0, 1'b1, e, 1000 + i);
            k = 0;
            while (bus.ready !== 1'b1 && k < 64) begin
                cycle(1'b0, 1'b1, 1'b0, e, 2000 + i);
                k++;
            end
            checks++;
            if (bus.ready !== 1'b1) begin
                errors++;
                $display("FAIL relock%0d: ready=%b after %0d cycles, want 1", i, bus.ready, k);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Controller on the driving side of the PLL's `rst`/`locked` interface. It issues the PLL reset pulse, synchronizes and qualifies the asynchronous `locked` status, and releases the system reset only after lock has been stable for a programmed time. On loss of lock it re-asserts system reset and restarts the PLL. It runs entirely in the 50 MHz `refclk` domain and sits between board reset and every consumer of the PLL's 24 MHz output.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer; minimum 2.
- `PLL_RST_CYCLES`, 16: length of the PLL reset pulse after `rst` releases, in `refclk` cycles; minimum 1.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-high `locked` cycles required before release; minimum 1.
- `LOCK_TIMEOUT_CYCLES`, 50000: maximum wait for lock (1 ms) before the PLL is reset again; minimum 2.

Ports:
- `refclk`  in  1: clock, 50 MHz.
- `rst`  in  1: reset, synchronous and active-high.
- `pll_locked`  in  1: PLL `locked`; asynchronous.
- `pll_rst`  out  1: drives the PLL `rst`.
- `sys_rst`  out  1: system reset for downstream logic. Active-high, in the `refclk` domain; consumers re-synchronize it.
- `ready`  out  1: high only in RUN.
- `relock_count`  out  8: number of RUN→lock-loss events; saturates at 255.
- `timeout_err`  out  1: sticky; set on any lock timeout.

## Operation
- States: RESET_PLL, WAIT_LOCK, STABILIZE, RUN. Encoding is one-hot.
- A single down-counter `cnt` is shared by all states. Its width is `$clog2` of the largest cycle parameter, plus 1.
- `locked_s` is `pll_locked` after the SYNC_STAGES flops.

Behaviour by state:
- **rst high:** state is RESET_PLL and `cnt` = PLL_RST_CYCLES-1. Outputs are `pll_rst`=1, `sys_rst`=1, `ready`=0, `relock_count`=0 and `timeout_err`=0. Synchronizer flops clear to 0.
- **RESET_PLL:**
  - `pll_rst`=1 and `sys_rst`=1.
  - When `cnt`==0, go to WAIT_LOCK and load `cnt` = LOCK_TIMEOUT_CYCLES-1.
  - Otherwise decrement `cnt`.
- **WAIT_LOCK:**
  - `pll_rst`=0 and `sys_rst`=1.
  - If `locked_s`, go to STABILIZE and load LOCK_STABLE_CYCLES-1.
  - Else if `cnt`==0, set `timeout_err`, go to RESET_PLL and load PLL_RST_CYCLES-1.
  - If both `locked_s` and `cnt`==0 hold in the same cycle, the lock wins.
- **STABILIZE:**
  - `sys_rst`=1.
  - If `!locked_s`, return to WAIT_LOCK with a fresh timeout.
  - Else if `cnt`==0, go to RUN.
- **RUN:**
  - `sys_rst`=0 and `ready`=1.
  - If `!locked_s`, go to RESET_PLL, load PLL_RST_CYCLES-1 and increment `relock_count` (saturating).
- `rst` asserted in any state, including mid-count, applies the reset values on the next edge. Counters do not resume.

## Timing
- Every output is a dedicated flop, updated on the same edge as the state register. Outputs never glitch.
- `pll_rst` stays high while `rst` is high, plus exactly PLL_RST_CYCLES edges after the first edge with `rst` low.
- Synchronizer latency is SYNC_STAGES edges.
- With `pll_locked` rising in WAIT_LOCK and held high, `ready` rises and `sys_rst` falls SYNC_STAGES+LOCK_STABLE_CYCLES+1 edges after it.
- A drop of `pll_locked` in RUN asserts `sys_rst` and `pll_rst` SYNC_STAGES+1 edges later.
- A `pll_locked` glitch shorter than one `refclk` period may be missed. That is acceptable.
- Any low sample during STABILIZE restarts the qualification.

## Structure
- Package `pll_ctrl_pkg` holds:
  - the state enum/localparams;
  - the `RELOCK_W`=8 constant;
  - a `clog2`-based counter-width function shared with other clock/reset controllers.
- Sub-module `bit_sync` is a parameterized N-flop synchronizer with synchronous reset value 0. It is instantiated once for `pll_locked`.

## Test plan
Benches use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32 and SYNC_STAGES=2.
1. **Reset release.** Release `rst`, hold `pll_locked`=0 → `pll_rst` high exactly 4 edges after release, then 0; `sys_rst`=1 and `ready`=0 throughout.
2. **Clean lock.** `pll_locked` rises 5 cycles into WAIT_LOCK and stays high → `ready`=1 and `sys_rst`=0 exactly 11 edges later; `relock_count`=0 and `timeout_err`=0.
3. **Lock chatter.** `pll_locked` goes low for 1 cycle, 4 cycles into STABILIZE → state returns to WAIT_LOCK; `ready` rises 11 edges after the final rise, not earlier.
4. **Timeout.** `pll_locked` never rises → `timeout_err`=1 after 32 WAIT_LOCK cycles; `pll_rst` pulses high for 4 cycles; the sequence repeats and `timeout_err` stays 1.
5. **Loss of lock in RUN.** Drop `pll_locked` while in RUN → `sys_rst`=1, `ready`=0 and `pll_rst`=1 3 edges later; `relock_count`=1. Repeat 300 times → `relock_count`=255.
6. **Reset mid-STABILIZE.** Assert `rst` 1 cycle in STABILIZE → next edge gives all outputs at reset values (`pll_rst`=1, `sys_rst`=1, `ready`=0, `relock_count`=0, `timeout_err`=0); after release the full 4-cycle PLL reset is reissued.
